// File: rtl/tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_sequencer
// Description : Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR. Shares the
//               TLB s1 search port with data-side translation, issues
//               one-cycle CP0/TLB strobes, keeps CP0 Random and requests a
//               refetch after every TLB write.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_sequencer #(
  parameter int TLBNUM     = 16,
  parameter int IDX_W      = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [31:0]      op_pc,
  input  logic             flush,
  output logic             op_stall,
  output logic             op_done,
  input  logic             dreq_valid,
  input  logic [18:0]      dreq_vpn2,
  input  logic [7:0]       dreq_asid,
  output logic             dreq_grant,
  output logic [18:0]      s1_vpn2,
  output logic [7:0]       s1_asid,
  input  logic             tlb_s1_found,
  input  logic [IDX_W-1:0] tlb_s1_index,
  input  logic [18:0]      cp0_vpn2,
  input  logic [7:0]       cp0_asid,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic             tlbp_commit,
  output logic             tlbp_found,
  output logic [IDX_W-1:0] tlbp_index,
  output logic             tlbr_commit,
  output logic [IDX_W-1:0] tlb_r_index,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [IDX_W-1:0] random,
  output logic             refetch_valid,
  output logic [31:0]      refetch_pc
);

  localparam int               CNT_W    = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIM - 1);
  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLBNUM - 1);
  localparam logic [1:0]       OP_TLBP  = 2'b00;
  localparam logic [1:0]       OP_TLBR  = 2'b01;
  localparam logic [1:0]       OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PORT = 3'd1,
    S_PROBE     = 3'd2,
    S_READ      = 3'd3,
    S_WRITE     = 3'd4,
    S_REFETCH   = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_type_q, op_type_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [IDX_W-1:0] random_q, random_d;

  // State, wait counter, accepted-op context and Random register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_type_q <= '0;
      pc4_q     <= '0;
      random_q  <= RAND_MAX;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_type_q <= op_type_d;
      pc4_q     <= pc4_d;
      random_q  <= random_d;
    end
  end

  // Random: free-running down-counter over [wired, TLBNUM-1]; a Wired write restarts it
  always_comb begin
    random_d = random_q - 1'b1;
    if (cp0_wired_we || (cp0_wired >= RAND_MAX) || (random_q <= cp0_wired)) begin
      random_d = RAND_MAX;
    end
  end

  // Next-state and strobe generation; flush squashes every side effect of the cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_type_d     = op_type_q;
    pc4_d         = pc4_q;
    op_done       = 1'b0;
    s1_vpn2       = dreq_vpn2;
    s1_asid       = dreq_asid;
    dreq_grant    = dreq_valid;
    tlbp_commit   = 1'b0;
    tlbp_found    = 1'b0;
    tlbp_index    = '0;
    tlbr_commit   = 1'b0;
    tlb_r_index   = '0;
    tlb_we        = 1'b0;
    tlb_w_index   = '0;
    refetch_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          op_type_d = op_type;
          pc4_d     = op_pc + 32'd4;
          if (op_type == OP_TLBP) begin
            cnt_d   = '0;
            state_d = dreq_valid ? S_WAIT_PORT : S_PROBE;
          end else if (op_type == OP_TLBR) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WAIT_PORT: begin
        cnt_d = cnt_q + 1'b1;
        if (!dreq_valid || (cnt_q == CNT_LAST)) begin
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        s1_vpn2     = cp0_vpn2;
        s1_asid     = cp0_asid;
        dreq_grant  = 1'b0;
        tlbp_commit = 1'b1;
        tlbp_found  = tlb_s1_found;
        tlbp_index  = tlb_s1_index;
        state_d     = S_DONE;
      end
      S_READ: begin
        tlb_r_index = cp0_index;
        tlbr_commit = 1'b1;
        state_d     = S_DONE;
      end
      S_WRITE: begin
        tlb_we      = 1'b1;
        tlb_w_index = (op_type_q == OP_TLBWR) ? random_q : cp0_index;
        state_d     = S_REFETCH;
      end
      S_REFETCH: begin
        refetch_valid = 1'b1;
        op_done       = 1'b1;
        state_d       = S_IDLE;
      end
      S_DONE: begin
        op_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      op_done       = 1'b0;
      tlbp_commit   = 1'b0;
      tlbp_found    = 1'b0;
      tlbp_index    = '0;
      tlbr_commit   = 1'b0;
      tlb_r_index   = '0;
      tlb_we        = 1'b0;
      tlb_w_index   = '0;
      refetch_valid = 1'b0;
      state_d       = S_IDLE;
    end
  end

  // Hold the pipeline until the op reaches its retire cycle
  assign op_stall   = op_valid && (state_q != S_DONE) && (state_q != S_REFETCH);
  assign random     = random_q;
  assign refetch_pc = pc4_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_sequencer
// Description : Scoreboard bench for tlb_op_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        flush;
  logic        op_stall, op_done;
  logic        dreq_valid;
  logic [18:0] dreq_vpn2;
  logic [7:0]  dreq_asid;
  logic        dreq_grant;
  logic [18:0] s1_vpn2;
  logic [7:0]  s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic [18:0] cp0_vpn2;
  logic [7:0]  cp0_asid;
  logic [3:0]  cp0_index, cp0_wired;
  logic        cp0_wired_we;
  logic        tlbp_commit, tlbp_found;
  logic [3:0]  tlbp_index;
  logic        tlbr_commit;
  logic [3:0]  tlb_r_index;
  logic        tlb_we;
  logic [3:0]  tlb_w_index, random;
  logic        refetch_valid;
  logic [31:0] refetch_pc;

  always #5 clk = ~clk;

  tlb_op_sequencer #(.TLBNUM(16), .IDX_W(4), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc),
    .flush(flush), .op_stall(op_stall), .op_done(op_done),
    .dreq_valid(dreq_valid), .dreq_vpn2(dreq_vpn2), .dreq_asid(dreq_asid),
    .dreq_grant(dreq_grant), .s1_vpn2(s1_vpn2), .s1_asid(s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid), .cp0_index(cp0_index),
    .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .tlbp_commit(tlbp_commit), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr_commit(tlbr_commit), .tlb_r_index(tlb_r_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .random(random),
    .refetch_valid(refetch_valid), .refetch_pc(refetch_pc)
  );

  // One observable event: everything the DUT presents on a strobe cycle
  typedef struct packed {
    logic        pc;
    logic        pf;
    logic [3:0]  pi;
    logic        rc;
    logic [3:0]  ri;
    logic        we;
    logic [3:0]  wi;
    logic        rv;
    logic [31:0] rp;
    logic        dn;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act, mon_exp;
  int  checks   = 0;
  int  failures = 0;

  function automatic ev_t ev_probe(input logic f, input logic [3:0] i);
    ev_t e = '0;
    e.pc = 1'b1; e.pf = f; e.pi = i;
    return e;
  endfunction

  function automatic ev_t ev_read(input logic [3:0] i);
    ev_t e = '0;
    e.rc = 1'b1; e.ri = i;
    return e;
  endfunction

  function automatic ev_t ev_write(input logic [3:0] i);
    ev_t e = '0;
    e.we = 1'b1; e.wi = i;
    return e;
  endfunction

  function automatic ev_t ev_refetch(input logic [31:0] pc);
    ev_t e = '0;
    e.rv = 1'b1; e.rp = pc; e.dn = 1'b1;
    return e;
  endfunction

  function automatic ev_t ev_done();
    ev_t e = '0;
    e.dn = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe cycle is matched against the next expected event
  always @(negedge clk) begin
    if (rst && (tlbp_commit || tlbr_commit || tlb_we || refetch_valid || op_done)) begin
      mon_act    = '0;
      mon_act.pc = tlbp_commit;
      mon_act.pf = tlbp_commit ? tlbp_found : 1'b0;
      mon_act.pi = tlbp_commit ? tlbp_index : 4'd0;
      mon_act.rc = tlbr_commit;
      mon_act.ri = tlb_r_index;
      mon_act.we = tlb_we;
      mon_act.wi = tlb_w_index;
      mon_act.rv = refetch_valid;
      mon_act.rp = refetch_valid ? refetch_pc : 32'd0;
      mon_act.dn = op_done;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL event actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; op_valid = 1'b0; op_type = 2'b00; op_pc = 32'd0; flush = 1'b0;
    dreq_valid = 1'b0; dreq_vpn2 = 19'h01234; dreq_asid = 8'h11;
    tlb_s1_found = 1'b0; tlb_s1_index = 4'd0;
    cp0_vpn2 = 19'h5A5A5; cp0_asid = 8'h3C; cp0_index = 4'd0;
    cp0_wired = 4'd0; cp0_wired_we = 1'b0;

    // Reset state
    tick();
    chk("rst_random", random, 32'd15);
    chk("rst_stall", op_stall, 0);
    chk("rst_done", op_done, 0);
    chk("rst_refetch_pc", refetch_pc, 0);
    chk("rst_refetch_valid", refetch_valid, 0);
    tick();
    rst = 1'b1;
    tick();

    // TLBP, port free, hit at index 5
    tlb_s1_found = 1'b1; tlb_s1_index = 4'd5;
    op_valid = 1'b1; op_type = 2'b00;
    exp_q.push_back(ev_probe(1'b1, 4'd5));
    exp_q.push_back(ev_done());
    #1 chk("p1_stall_accept", op_stall, 1);
    tick();
    chk("p1_stall_probe", op_stall, 1);
    chk("p1_grant_probe", dreq_grant, 0);
    tick();
    chk("p1_stall_done", op_stall, 0);
    op_valid = 1'b0;
    tick();

    // TLBP with data side hogging s1: three wait cycles, then pre-empt
    tlb_s1_found = 1'b0; tlb_s1_index = 4'd0;
    dreq_valid = 1'b1;
    op_valid = 1'b1; op_type = 2'b00;
    exp_q.push_back(ev_probe(1'b0, 4'd0));
    exp_q.push_back(ev_done());
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p2_wait_grant", dreq_grant, 1);
      chk("p2_wait_vpn2", s1_vpn2, 32'h01234);
    end
    tick();
    chk("p2_probe_grant", dreq_grant, 0);
    chk("p2_probe_vpn2", s1_vpn2, 32'h5A5A5);
    chk("p2_probe_asid", s1_asid, 32'h3C);
    tick();
    op_valid = 1'b0; dreq_valid = 1'b0;
    tick();

    // TLBWR at the wired boundary, PC wrap on refetch
    cp0_wired = 4'd2;
    for (int n = 0; n < 40 && random != 4'd3; n++) tick();
    chk("wr_sync_random", random, 32'd3);
    op_valid = 1'b1; op_type = 2'b11; op_pc = 32'hFFFF_FFFC;
    exp_q.push_back(ev_write(4'd2));
    exp_q.push_back(ev_refetch(32'h0000_0000));
    tick();
    chk("wr_random_write", random, 32'd2);
    tick();
    chk("wr_random_wrap", random, 32'd15);
    chk("wr_stall_refetch", op_stall, 0);
    op_valid = 1'b0;
    tick();

    // TLBWI normal completion
    cp0_index = 4'd9;
    op_valid = 1'b1; op_type = 2'b10; op_pc = 32'h0000_1000;
    exp_q.push_back(ev_write(4'd9));
    exp_q.push_back(ev_refetch(32'h0000_1004));
    tick();
    tick();
    op_valid = 1'b0;
    tick();

    // TLBWI flushed in its write cycle
    op_valid = 1'b1; op_type = 2'b10;
    tick();
    flush = 1'b1;
    #1 chk("fl_tlb_we", tlb_we, 0);
    chk("fl_refetch", refetch_valid, 0);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1 chk("fl_after_refetch", refetch_valid, 0);
    chk("fl_after_we", tlb_we, 0);
    tick();

    // TLBR interrupted by reset, then re-run
    cp0_index = 4'd7;
    op_valid = 1'b1; op_type = 2'b01;
    tick();
    rst = 1'b0;
    #1 chk("rr_commit", tlbr_commit, 0);
    chk("rr_random", random, 32'd15);
    chk("rr_done", op_done, 0);
    tick();
    exp_q.push_back(ev_read(4'd7));
    exp_q.push_back(ev_done());
    rst = 1'b1;
    tick();
    tick();
    op_valid = 1'b0;
    tick();

    // Wired at maximum pins Random; Wired write restarts the countdown
    cp0_wired = 4'd15;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("wd_hold", random, 32'd15);
      tick();
    end
    cp0_wired = 4'd0; cp0_wired_we = 1'b1;
    tick();
    cp0_wired_we = 1'b0;
    chk("wd_we", random, 32'd15);
    tick();
    chk("wd_dec1", random, 32'd14);
    tick();
    chk("wd_dec2", random, 32'd13);
    tick();
    chk("wd_dec3", random, 32'd12);
    tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlb_op_sequencer.md
Name: tlb_op_sequencer

Overview:
- Multi-cycle sequencer for TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) arriving from MEM.
- Arbitrates the shared TLB search port s1 between data-side translation and TLBP probes.
- Issues one-cycle commit strobes to cp0_reg and write strobes to the TLB, maintains the Random index, and requests a refetch after any TLB write.

Parameters:
TLBNUM, 16, number of TLB entries
IDX_W, 4, index width (log2 TLBNUM)
STARVE_LIM, 3, max cycles a TLBP waits for s1 before pre-empting the data side

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
op_valid  in  1  MEM-stage TLB instruction valid
op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_pc  in  32  PC of the TLB instruction
flush  in  1  pipeline exception flush
op_stall  out  1  hold MEM and earlier stages
op_done  out  1  instruction retires this cycle
dreq_valid  in  1  data-side s1 search request
dreq_vpn2  in  19  data-side VPN2
dreq_asid  in  8  data-side ASID
dreq_grant  out  1  s1 result belongs to data side this cycle
s1_vpn2  out  19  TLB s1 search VPN2
s1_asid  out  8  TLB s1 search ASID
tlb_s1_found  in  1  TLB s1 hit (combinational)
tlb_s1_index  in  IDX_W  TLB s1 hit index
cp0_vpn2  in  19  EntryHi.VPN2
cp0_asid  in  8  EntryHi.ASID
cp0_index  in  IDX_W  Index.Index
cp0_wired  in  IDX_W  Wired value
cp0_wired_we  in  1  Wired being written this cycle
tlbp_commit  out  1  strobe: CP0 writes Index.P = ~tlbp_found, Index = tlbp_index
tlbp_found  out  1  probe hit
tlbp_index  out  IDX_W  probe index
tlbr_commit  out  1  strobe: CP0 loads EntryHi/Lo0/Lo1 from TLB read port
tlb_r_index  out  IDX_W  TLB read index (= cp0_index)
tlb_we  out  1  TLB write strobe
tlb_w_index  out  IDX_W  TLB write index
random  out  IDX_W  CP0 Random value
refetch_valid  out  1  redirect fetch, retire op
refetch_pc  out  32  op_pc + 4 (mod 2^32)

Behaviour:
- Reset (async, rst=0): state IDLE, wait counter 0, random = TLBNUM-1, all strobes/op_stall/op_done/refetch_valid 0, refetch_pc 0. Takes effect immediately mid-operation; no strobe completes.
- States: IDLE, WAIT_PORT, PROBE, READ, WRITE, REFETCH, DONE.
- op_stall = 1 whenever op_valid && state != DONE && state != REFETCH (combinational, including the IDLE accept cycle).
- IDLE, op_valid && !flush:
  - TLBP: to PROBE if !dreq_valid, else WAIT_PORT (counter cleared).
  - TLBR: to READ.
  - TLBWI/TLBWR: to WRITE.
- WAIT_PORT: counter increments each cycle. To PROBE when !dreq_valid or counter == STARVE_LIM-1.
- PROBE: s1 driven from cp0_vpn2/asid, dreq_grant = 0, tlbp_commit = 1, tlbp_found/tlbp_index = TLB result; to DONE.
- READ: tlb_r_index = cp0_index, tlbr_commit = 1; to DONE.
- WRITE: tlb_we = 1; tlb_w_index = cp0_index (TLBWI) or random sampled this cycle (TLBWR); op_type registered at accept; to REFETCH.
- REFETCH: refetch_valid = 1, refetch_pc = registered op_pc + 4; op retires via refetch (op_done = 1); to IDLE.
- DONE: op_done = 1, op_stall = 0; to IDLE.
- Outside PROBE: s1 = dreq_vpn2/asid, dreq_grant = dreq_valid.
- All strobes are single-cycle; tlb_r_index/tlb_w_index are 0 when not in use.
- flush (any state): all strobes and refetch_valid gated to 0 that cycle; next state IDLE. A TLB write already issued in WRITE is not undone.
- Random: decrements every cycle. At value <= cp0_wired it wraps to TLBNUM-1. If cp0_wired >= TLBNUM-1 it holds TLBNUM-1. cp0_wired_we forces TLBNUM-1 next cycle (priority over decrement).
- A new op is accepted only in IDLE; back-to-back ops incur the DONE/REFETCH cycle.

Test Plan:
- TLBP, dreq_valid=0, TLB hit index 5 -> cycle1 PROBE: tlbp_commit=1, found=1, index=5; cycle2 op_done=1; op_stall high cycles 0-1 only.
- TLBP with dreq_valid held 1, STARVE_LIM=3 -> 3 WAIT_PORT cycles with dreq_grant=1, then PROBE with dreq_grant=0, s1_vpn2=cp0_vpn2.
- TLBWR, cp0_wired=2, random observed 2 -> tlb_we=1 with w_index=2, next cycle random=15; REFETCH: refetch_pc = op_pc+4 (op_pc=0xFFFFFFFC gives 0x00000000).
- TLBWI cp0_index=9 with flush asserted in WRITE cycle -> tlb_we=0, no refetch_valid, state IDLE.
- rst pulled low during READ -> tlbr_commit=0 immediately, random=15; after release an op_valid TLBR completes normally in 2 cycles.
- cp0_wired=15 -> random constant 15 for 20 cycles; cp0_wired_we with wired=0 -> random=15 next cycle, then 14, 13, ...
